// File: rtl/mops_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : mops_pulse_gen
// Purpose  : Synthetic PMT pulse-train generator feeding the MoPS trigger ADC
//            inputs at the 40 MHz tick cadence of a 120 MHz clock.
// Revision : 1.0 - initial release
// ============================================================================
module mops_pulse_gen #(
  parameter int ADC_WIDTH = 12,
  parameter int CNT_BITS  = 8
) (
  input  logic                 CLK120,
  input  logic                 RESET_N,
  input  logic [1:0]           ENABLE40,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [ADC_WIDTH-1:0] BASELINE,
  input  logic [ADC_WIDTH-1:0] STEP,
  input  logic [3:0]           N_RISE,
  input  logic [2:0]           DECAY_SHIFT,
  input  logic [CNT_BITS-1:0]  GAP,
  input  logic [CNT_BITS-1:0]  N_PULSES,
  input  logic [2:0]           CH_ENABLE,
  output logic [ADC_WIDTH-1:0] ADC0,
  output logic [ADC_WIDTH-1:0] ADC1,
  output logic [ADC_WIDTH-1:0] ADC2,
  output logic                 SAMPLE_STROBE,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RISE  = 2'd1;
  localparam logic [1:0] c_DECAY = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  logic [1:0]           r_state;
  logic [ADC_WIDTH-1:0] r_v;
  logic [ADC_WIDTH-1:0] r_base;
  logic [ADC_WIDTH-1:0] r_step;
  logic [3:0]           r_nrise;
  logic [2:0]           r_shift;
  logic [CNT_BITS-1:0]  r_gap;
  logic [CNT_BITS-1:0]  r_npulses;
  logic [2:0]           r_chen;
  logic [3:0]           r_rise_cnt;
  logic [CNT_BITS-1:0]  r_pulse_cnt;
  logic [CNT_BITS-1:0]  r_gap_cnt;
  logic [ADC_WIDTH-1:0] r_adc0;
  logic [ADC_WIDTH-1:0] r_adc1;
  logic [ADC_WIDTH-1:0] r_adc2;
  logic                 r_strobe;
  logic                 r_done;

  logic                 w_tick;
  logic [ADC_WIDTH:0]   w_sum;
  logic [ADC_WIDTH-1:0] w_rise_v;
  logic [ADC_WIDTH-1:0] w_diff;
  logic [ADC_WIDTH-1:0] w_shr;
  logic [ADC_WIDTH-1:0] w_dec;
  logic                 w_at_base;
  logic [ADC_WIDTH-1:0] w_v_nxt;
  logic [3:0]           w_nrise_eff;
  logic                 w_rise_last;
  logic [CNT_BITS-1:0]  w_pulse_inc;
  logic [CNT_BITS-1:0]  w_gap_inc;

  assign w_tick      = (ENABLE40 == 2'b00);
  assign w_nrise_eff = (r_nrise == 4'd0) ? 4'd1 : r_nrise;
  assign w_rise_last = ((r_rise_cnt + 4'd1) == w_nrise_eff);
  assign w_pulse_inc = r_pulse_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
  assign w_gap_inc   = r_gap_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Sample value for the current tick; the sum is one bit wider so it saturates instead of wrapping.
  always_comb begin
    w_sum     = {1'b0, r_v} + {1'b0, r_step};
    w_rise_v  = w_sum[ADC_WIDTH] ? {ADC_WIDTH{1'b1}} : w_sum[ADC_WIDTH-1:0];
    w_diff    = r_v - r_base;
    w_shr     = w_diff >> r_shift;
    w_dec     = (w_shr == '0) ? {{(ADC_WIDTH-1){1'b0}}, 1'b1} : w_shr;
    w_at_base = (r_v <= r_base);
    w_v_nxt   = r_base;
    case (r_state)
      c_RISE:  w_v_nxt = w_rise_v;
      c_DECAY: w_v_nxt = w_at_base ? r_base : (r_v - w_dec);
      default: w_v_nxt = r_base;
    endcase
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= c_IDLE;
      r_v         <= '0;
      r_base      <= '0;
      r_step      <= '0;
      r_nrise     <= '0;
      r_shift     <= '0;
      r_gap       <= '0;
      r_npulses   <= '0;
      r_chen      <= '0;
      r_rise_cnt  <= '0;
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
      r_adc0      <= '0;
      r_adc1      <= '0;
      r_adc2      <= '0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_strobe <= w_tick;
      r_done   <= 1'b0;
      if (ABORT) begin
        r_state     <= c_IDLE;
        r_v         <= r_base;
        r_rise_cnt  <= '0;
        r_pulse_cnt <= '0;
        r_gap_cnt   <= '0;
        if (w_tick) begin
          r_adc0 <= BASELINE;
          r_adc1 <= BASELINE;
          r_adc2 <= BASELINE;
        end
      end else if (w_tick) begin
        if (r_state == c_IDLE) begin
          r_adc0 <= BASELINE;
          r_adc1 <= BASELINE;
          r_adc2 <= BASELINE;
          if (START && (N_PULSES != '0)) begin
            r_base      <= BASELINE;
            r_step      <= STEP;
            r_nrise     <= N_RISE;
            r_shift     <= DECAY_SHIFT;
            r_gap       <= GAP;
            r_npulses   <= N_PULSES;
            r_chen      <= CH_ENABLE;
            r_v         <= BASELINE;
            r_rise_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_gap_cnt   <= '0;
            r_state     <= c_RISE;
          end
        end else begin
          r_v    <= w_v_nxt;
          r_adc0 <= r_chen[0] ? w_v_nxt : r_base;
          r_adc1 <= r_chen[1] ? w_v_nxt : r_base;
          r_adc2 <= r_chen[2] ? w_v_nxt : r_base;
          if (r_state == c_RISE) begin
            if (w_rise_last) begin
              r_rise_cnt <= '0;
              r_state    <= c_DECAY;
            end else begin
              r_rise_cnt <= r_rise_cnt + 4'd1;
            end
          end else if (r_state == c_DECAY) begin
            // The tick that finds V back at the pedestal closes the pulse.
            if (w_at_base) begin
              if (w_pulse_inc == r_npulses) begin
                r_pulse_cnt <= '0;
                r_done      <= 1'b1;
                r_state     <= c_IDLE;
              end else begin
                r_pulse_cnt <= w_pulse_inc;
                r_gap_cnt   <= '0;
                r_state     <= (r_gap != '0) ? c_GAP : c_RISE;
              end
            end
          end else begin
            if (w_gap_inc == r_gap) begin
              r_gap_cnt <= '0;
              r_state   <= c_RISE;
            end else begin
              r_gap_cnt <= w_gap_inc;
            end
          end
        end
      end
    end
  end

  assign ADC0          = r_adc0;
  assign ADC1          = r_adc1;
  assign ADC2          = r_adc2;
  assign SAMPLE_STROBE = r_strobe;
  assign DONE          = r_done;
  assign BUSY          = (r_state != c_IDLE);

endmodule
`default_nettype wire
